// File: rtl/cordic_range_ctrl.sv
// rtl/cordic_range_ctrl.sv - CORDIC range folding, core sequencing and sign correction (CORDIC_RANGE_SAT_EN)
module cordic_range_ctrl #(
    parameter int W_FRAC  = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [18:0]  in_angle,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [17:0]  out_cos,
    output logic signed [17:0]  out_sin,
    output logic                out_err,
    output logic                cordic_init,
    output logic signed [17:0]  cordic_angle,
    input  logic signed [17:0]  cordic_cos,
    input  logic signed [17:0]  cordic_sin,
    input  logic                cordic_done
);

    localparam logic signed [18:0] PI     = 19'sd205887;
    localparam logic signed [18:0] NEG_PI = -19'sd205887;
    localparam logic signed [18:0] PI_2   = 19'sd102944;
    localparam logic signed [18:0] NEG_PI_2 = -19'sd102944;
    localparam logic [17:0]        PI_MOD = 18'd205887;
    localparam logic signed [17:0] UNITY  = 18'sd1 <<< W_FRAC;
    localparam int                 CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

`ifdef CORDIC_RANGE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

    state_t            state;
    logic              neg;
    logic [CNT_W-1:0]  cnt;
    logic              range_err;
    logic              fold_neg;
    logic [17:0]       reduced;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == OUT);
    assign cordic_init = (state == LOAD);

    // Folding by +/-PI is done modulo 2^18; the result always fits the core's [1:-16] format.
    always_comb begin
        range_err = (in_angle > PI) || (in_angle < NEG_PI);
        fold_neg  = 1'b0;
        reduced   = in_angle[17:0];
        if (in_angle > PI_2) begin
            fold_neg = 1'b1;
            reduced  = in_angle[17:0] - PI_MOD;
        end else if (in_angle < NEG_PI_2) begin
            fold_neg = 1'b1;
            reduced  = in_angle[17:0] + PI_MOD;
        end
    end

    function automatic logic signed [17:0] correct(input logic signed [17:0] v, input logic n);
        logic signed [17:0] r;
        r = n ? -v : v;
        if (SAT_EN && (r > UNITY))
            r = UNITY;
        else if (SAT_EN && (r < -UNITY))
            r = -UNITY;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            neg          <= 1'b0;
            cnt          <= '0;
            out_err      <= 1'b0;
            out_cos      <= '0;
            out_sin      <= '0;
            cordic_angle <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (range_err) begin
                            out_err <= 1'b1;
                            out_cos <= '0;
                            out_sin <= '0;
                            state   <= OUT;
                        end else begin
                            cordic_angle <= reduced;
                            neg          <= fold_neg;
                            state        <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cordic_done) begin
                        out_cos <= correct(cordic_cos, neg);
                        out_sin <= correct(cordic_sin, neg);
                        out_err <= 1'b0;
                        state   <= OUT;
                    end else if (cnt == CNT_LAST) begin
                        out_err <= 1'b1;
                        out_cos <= '0;
                        out_sin <= '0;
                        state   <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_range_ctrl.sv
// tb/tb_cordic_range_ctrl.sv - self-checking bench for cordic_range_ctrl with a behavioural CORDIC core
module tb_cordic_range_ctrl;

    localparam int TIMEOUT = 32;
    localparam int PI      = 205887;
    localparam int PI_2    = 102944;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [18:0] in_angle = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [17:0] out_cos, out_sin;
    logic               out_err;
    logic               cordic_init;
    logic signed [17:0] cordic_angle;
    logic signed [17:0] cordic_cos = '0;
    logic signed [17:0] cordic_sin = '0;
    logic               cordic_done = 1'b0;

    int checks = 0;
    int failures = 0;

    cordic_range_ctrl #(.W_FRAC(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cos(out_cos), .out_sin(out_sin), .out_err(out_err),
        .cordic_init(cordic_init), .cordic_angle(cordic_angle),
        .cordic_cos(cordic_cos), .cordic_sin(cordic_sin), .cordic_done(cordic_done)
    );

    always #5 clk = ~clk;

    function automatic int to_fix(real x);
        if (x >= 0.0)
            return $rtoi(x * 65536.0 + 0.5);
        return -$rtoi(-x * 65536.0 + 0.5);
    endfunction

    // Ideal core: done falls when init is sampled, rises core_lat edges later and stays high.
    int                 core_lat = 16;
    bit                 core_en = 1'b1;
    int                 core_cnt = 0;
    logic signed [17:0] core_ang = '0;

    always @(posedge clk) begin
        if (cordic_init) begin
            cordic_done <= 1'b0;
            core_ang    <= cordic_angle;
            core_cnt    <= core_lat;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && core_en) begin
                cordic_done <= 1'b1;
                cordic_cos  <= 18'(to_fix($cos(real'(core_ang) / 65536.0)));
                cordic_sin  <= 18'(to_fix($sin(real'(core_ang) / 65536.0)));
            end
        end
    end

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int fold(int a);
        if (a > PI_2) return a - PI;
        if (a < -PI_2) return a + PI;
        return a;
    endfunction

    task automatic run_req(input int a, input int hold);
        int n, init_n, init_cnt, done_n, ov_n, ec, es;
        bit exp_err;
        logic signed [17:0] ca, c0, s0;
        logic e0;
        exp_err = (a > PI) || (a < -PI);
        ca = '0;
        @(negedge clk);
        chk("idle_in_ready", in_ready == 1'b1, in_ready, 1);
        in_valid = 1'b1;
        in_angle = 19'(a);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1; init_n = -1; init_cnt = 0; done_n = -1; ov_n = -1;
        while (n <= 100) begin
            if (cordic_init) begin
                init_cnt++;
                init_n = n;
                ca = cordic_angle;
            end
            if (init_n > 0 && n > init_n && cordic_done && done_n < 0)
                done_n = n;
            if (out_valid) begin
                ov_n = n;
                break;
            end
            n++;
            @(negedge clk);
        end
        chk("out_valid_seen", ov_n > 0, ov_n, 1);
        if (ov_n < 0) return;
        if (exp_err) begin
            chk("err_no_init", init_cnt == 0, init_cnt, 0);
            chk("err_latency", ov_n == 1, ov_n, 1);
            chk("err_flag", out_err == 1'b1, out_err, 1);
            chk("err_cos", out_cos == 0, out_cos, 0);
            chk("err_sin", out_sin == 0, out_sin, 0);
        end else begin
            chk("init_count", init_cnt == 1, init_cnt, 1);
            chk("init_after_accept", init_n == 1, init_n, 1);
            chk("cordic_angle", ca == 18'(fold(a)), ca, fold(a));
            if (!core_en) begin
                chk("timeout_latency", ov_n == init_n + TIMEOUT + 1, ov_n, init_n + TIMEOUT + 1);
                chk("timeout_err", out_err == 1'b1, out_err, 1);
                chk("timeout_cos", out_cos == 0, out_cos, 0);
                chk("timeout_sin", out_sin == 0, out_sin, 0);
            end else begin
                ec = to_fix($cos(real'(a) / 65536.0));
                es = to_fix($sin(real'(a) / 65536.0));
                chk("done_latency", done_n > 0 && ov_n == done_n + 1, ov_n, done_n + 1);
                chk("ok_err", out_err == 1'b0, out_err, 0);
                chk("cos_value", (int'(out_cos) - ec) <= 64 && (ec - int'(out_cos)) <= 64, out_cos, ec);
                chk("sin_value", (int'(out_sin) - es) <= 64 && (es - int'(out_sin)) <= 64, out_sin, es);
            end
        end
        c0 = out_cos; s0 = out_sin; e0 = out_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid == 1'b1, out_valid, 1);
            chk("hold_busy", in_ready == 1'b0, in_ready, 0);
            chk("hold_stable", out_cos == c0 && out_sin == s0 && out_err == e0, out_cos, c0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_idle", in_ready == 1'b1 && out_valid == 1'b0, in_ready, 1);
    endtask

    typedef struct {
        int angle;
        int hold;
    } vec_t;

    vec_t tbl[14];

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready == 1'b1, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid == 1'b0, out_valid, 0);
        chk({tag, "_out_err"}, out_err == 1'b0, out_err, 0);
        chk({tag, "_out_cos"}, out_cos == 0, out_cos, 0);
        chk({tag, "_out_sin"}, out_sin == 0, out_sin, 0);
        chk({tag, "_init"}, cordic_init == 1'b0, cordic_init, 0);
        chk({tag, "_cordic_angle"}, cordic_angle == 0, cordic_angle, 0);
    endtask

    initial begin
        tbl[0]  = '{0, 0};
        tbl[1]  = '{154415, 1};
        tbl[2]  = '{-205887, 0};
        tbl[3]  = '{102944, 2};
        tbl[4]  = '{-102944, 0};
        tbl[5]  = '{102945, 0};
        tbl[6]  = '{-102945, 1};
        tbl[7]  = '{205887, 0};
        tbl[8]  = '{205888, 0};
        tbl[9]  = '{-205888, 1};
        tbl[10] = '{210000, 0};
        tbl[11] = '{262143, 0};
        tbl[12] = '{-262144, 0};
        tbl[13] = '{-154415, 0};

        #17;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            run_req(tbl[i].angle, tbl[i].hold);

        // Core never completes: request must abort after the WAIT budget, then hold 10 cycles.
        core_en = 1'b0;
        run_req(0, 10);
        core_en = 1'b1;

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = 19'sd50000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midwait_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_req(0, 0);

        for (int i = 0; i < 40; i++) begin
            int a;
            if (i % 2 == 0)
                a = int'($urandom_range(0, 2 * PI)) - PI;
            else
                a = int'($urandom_range(0, 524287)) - 262144;
            core_lat = int'($urandom_range(1, 20));
            run_req(a, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
